// File: rtl/debounce_bank.sv
// Multi-channel push-button debouncer: synchronised, stability-counted clean level with press/release pulses.
// Optional auto-repeat pulses while held when DEBOUNCE_BANK_REPEAT_EN is defined.
module debounce_bank #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned CNT_W         = 19,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned ACTIVE_LOW    = 1,
  parameter int unsigned REPEAT_DELAY  = 1000000,
  parameter int unsigned REPEAT_PERIOD = 200000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] sig_in,
  output logic [CHANNELS-1:0] sig_state,
  output logic [CHANNELS-1:0] sig_down,
  output logic [CHANNELS-1:0] sig_up,
  output logic [CHANNELS-1:0] sig_repeat,
  output logic                any_state
);

  localparam logic INACTIVE = (ACTIVE_LOW != 0);

  logic [SYNC_STAGES-1:0] sync_q [CHANNELS];
  logic [SYNC_STAGES-1:0] sync_d [CHANNELS];
  logic [CNT_W-1:0]       cnt_q  [CHANNELS];
  logic [CNT_W-1:0]       cnt_d  [CHANNELS];
  logic [CHANNELS-1:0]    state_q, state_d;
  logic [CHANNELS-1:0]    down_q, down_d;
  logic [CHANNELS-1:0]    up_q, up_d;
  logic [CHANNELS-1:0]    lvl;
  logic [CHANNELS-1:0]    toggle;

  // Synchroniser shift, polarity normalisation and stability counting
  always_comb begin
    lvl    = '0;
    toggle = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], sig_in[i]};
      cnt_d[i]  = '0;
      lvl[i]    = sync_q[i][SYNC_STAGES-1] ^ INACTIVE;
      if (lvl[i] != state_q[i]) begin
        if (&cnt_q[i]) begin
          toggle[i] = 1'b1;
        end else begin
          cnt_d[i] = CNT_W'(cnt_q[i] + 1'b1);
        end
      end
    end
    state_d = state_q ^ toggle;
    down_d  = toggle & ~state_q;
    up_d    = toggle & state_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        sync_q[i] <= {SYNC_STAGES{INACTIVE}};
        cnt_q[i]  <= '0;
      end
      state_q <= '0;
      down_q  <= '0;
      up_q    <= '0;
    end else begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        sync_q[i] <= sync_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      state_q <= state_d;
      down_q  <= down_d;
      up_q    <= up_d;
    end
  end

  assign sig_state = state_q;
  assign sig_down  = down_q;
  assign sig_up    = up_q;
  assign any_state = |state_q;

`ifdef DEBOUNCE_BANK_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW      = $clog2(REP_MAX + 1);

  logic [RW-1:0]       rcnt_q [CHANNELS];
  logic [RW-1:0]       rcnt_d [CHANNELS];
  logic [CHANNELS-1:0] period_q, period_d;
  logic [CHANNELS-1:0] rep_q, rep_d;
  logic [RW-1:0]       rcnt_nxt;
  logic [RW-1:0]       rtarget;

  // Hold timer: first interval is REPEAT_DELAY, later intervals REPEAT_PERIOD; stops on press/release edges
  always_comb begin
    period_d = '0;
    rep_d    = '0;
    rcnt_nxt = '0;
    rtarget  = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      rcnt_d[i] = '0;
      if (state_q[i] && !toggle[i]) begin
        rcnt_nxt    = RW'(rcnt_q[i] + 1'b1);
        rtarget     = period_q[i] ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY);
        period_d[i] = period_q[i];
        rcnt_d[i]   = rcnt_nxt;
        if (rcnt_nxt == rtarget) begin
          rep_d[i]    = 1'b1;
          rcnt_d[i]   = '0;
          period_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        rcnt_q[i] <= '0;
      end
      period_q <= '0;
      rep_q    <= '0;
    end else begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        rcnt_q[i] <= rcnt_d[i];
      end
      period_q <= period_d;
      rep_q    <= rep_d;
    end
  end

  assign sig_repeat = rep_q;
`else
  logic unused_repeat_params;
  assign unused_repeat_params = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign sig_repeat = '0;
`endif

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank (CHANNELS=4, CNT_W=3, SYNC_STAGES=2, ACTIVE_LOW=1).
// Expected pulse events are queued by the stimulus; a monitor pops one per cycle that shows any pulse.
module tb_debounce_bank;

`ifdef DEBOUNCE_BANK_REPEAT_EN
  localparam logic REP_ON = 1'b1;
`else
  localparam logic REP_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sig_in;
  logic [3:0] sig_state, sig_down, sig_up, sig_repeat;
  logic       any_state;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  down;
    logic [3:0]  up;
    logic [3:0]  rep;
    logic [3:0]  state;
  } ev_t;

  ev_t sb[$];

  debounce_bank #(
    .CHANNELS(4), .CNT_W(3), .SYNC_STAGES(2), .ACTIVE_LOW(1),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in),
    .sig_state(sig_state), .sig_down(sig_down), .sig_up(sig_up),
    .sig_repeat(sig_repeat), .any_state(any_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_zero(input string name);
    check(name, 64'({sig_state, sig_down, sig_up, sig_repeat, any_state}), 64'd0);
  endtask

  // Queue an event dt posedges after the current one
  task automatic expect_ev(input int unsigned dt, input logic [3:0] dn, input logic [3:0] upv,
                           input logic [3:0] rp, input logic [3:0] st);
    ev_t e;
    e.cyc   = cyc + dt;
    e.down  = dn;
    e.up    = upv;
    e.rep   = rp;
    e.state = st;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every cycle with a pulse must match the head of the scoreboard
  always @(posedge clk) begin
    ev_t e;
    #1;
    if ((sig_down | sig_up | sig_repeat) != 4'h0) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: cycle %0d down=%b up=%b rep=%b state=%b, none expected",
                 cyc, sig_down, sig_up, sig_repeat, sig_state);
      end else begin
        e = sb.pop_front();
        check("event", 64'({cyc, sig_down, sig_up, sig_repeat, sig_state}), 64'(e));
        check("event_any_state", 64'(any_state), 64'(|e.state));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n  = 1'b0;
    sig_in = 4'h0;
    #1 check_zero("reset_hold");
    step(2);
    check_zero("reset_hold_clocked");

    // Release reset with all buttons held: all channels debounce together
    rst_n = 1'b1;
    expect_ev(10, 4'hF, 4'h0, 4'h0, 4'hF);
    step(10);
    check("state_all_pressed", 64'(sig_state), 64'hF);
    sig_in = 4'hF;
    expect_ev(10, 4'h0, 4'hF, 4'h0, 4'h0);
    step(12);

    // Async reset while pressed, then reset again mid-count
    sig_in = 4'h0;
    expect_ev(10, 4'hF, 4'h0, 4'h0, 4'hF);
    step(12);
    #3 rst_n = 1'b0;
    #1 check_zero("async_reset_clears_state");
    step(2);
    rst_n = 1'b1;
    step(5);
    #3 rst_n = 1'b0;
    #1 check_zero("reset_mid_count");
    step(2);
    rst_n = 1'b1;
    expect_ev(10, 4'hF, 4'h0, 4'h0, 4'hF);
    step(10);
    sig_in = 4'hF;
    expect_ev(10, 4'h0, 4'hF, 4'h0, 4'h0);
    step(12);

    // Clean press/release on ch0
    sig_in = 4'b1110;
    expect_ev(10, 4'b0001, 4'h0, 4'h0, 4'b0001);
    step(10);
    sig_in = 4'hF;
    expect_ev(10, 4'h0, 4'b0001, 4'h0, 4'h0);
    step(12);

    // Ch1 glitch of 7 cycles is rejected; 8 cycles is accepted
    sig_in = 4'b1101;
    step(7);
    sig_in = 4'hF;
    step(12);
    check("glitch7_rejected", 64'(sig_state), 64'h0);
    sig_in = 4'b1101;
    expect_ev(10, 4'b0010, 4'h0, 4'h0, 4'b0010);
    step(8);
    sig_in = 4'hF;
    expect_ev(10, 4'h0, 4'b0010, 4'h0, 4'h0);
    step(20);

    // Ch2 press, then bounce every 3 cycles before settling released
    sig_in = 4'b1011;
    expect_ev(10, 4'b0100, 4'h0, 4'h0, 4'b0100);
`ifdef DEBOUNCE_BANK_REPEAT_EN
    for (int k = 0; k < 8; k++) expect_ev(20 + 4 * k, 4'h0, 4'h0, 4'b0100, 4'b0100);
`endif
    step(10);
    for (int i = 0; i < 10; i++) begin
      sig_in[2] = (i % 2 == 0);
      step(3);
    end
    check("bounce_held", 64'(sig_state), 64'b0100);
    sig_in[2] = 1'b1;
    expect_ev(10, 4'h0, 4'b0100, 4'h0, 4'h0);
    step(12);

    // Simultaneous press on ch0 and ch3, staggered release
    sig_in = 4'b0110;
    expect_ev(10, 4'b1001, 4'h0, 4'h0, 4'b1001);
    step(10);
    check("any_state_both", 64'(any_state), 64'd1);
    sig_in = 4'b0111;
    expect_ev(10, 4'h0, 4'b0001, REP_ON ? 4'b1000 : 4'h0, 4'b1000);
`ifdef DEBOUNCE_BANK_REPEAT_EN
    expect_ev(14, 4'h0, 4'h0, 4'b1000, 4'b1000);
    expect_ev(18, 4'h0, 4'h0, 4'b1000, 4'b1000);
`endif
    step(10);
    check("any_state_ch3_only", 64'(any_state), 64'd1);
    sig_in = 4'hF;
    expect_ev(10, 4'h0, 4'b1000, 4'h0, 4'h0);
    step(12);
    check("any_state_released", 64'(any_state), 64'd0);

    // Long hold on ch0: repeat pulses only with the repeat feature built in
    sig_in = 4'b1110;
    expect_ev(10, 4'b0001, 4'h0, 4'h0, 4'b0001);
`ifdef DEBOUNCE_BANK_REPEAT_EN
    for (int k = 0; k < 5; k++) expect_ev(20 + 4 * k, 4'h0, 4'h0, 4'b0001, 4'b0001);
`endif
    step(30);
    sig_in = 4'hF;
    expect_ev(10, 4'h0, 4'b0001, 4'h0, 4'h0);
    step(20);
    check("final_idle", 64'({sig_state, sig_repeat}), 64'd0);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
